// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard controller for the IF/ID register, the PC and the
// ID/EX bubble. It detects load-use hazards, mult/div busy hazards, taken branches, jumps
// and exceptions. A 2-state FSM with a latency counter keeps MDBusy high for the full
// duration of a mult/div operation.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the StallCycles/FlushCycles counters.
//
// Ports:
//   clk, reset           - clock (rising edge), asynchronous active-low reset
//   ID_Rs/ID_Rt          - source registers of the instruction in ID
//   ID_UsesRs/ID_UsesRt  - ID instruction reads the corresponding source register
//   ID_Jump              - ID instruction is a jump resolved in ID
//   ID_MDStart/IsDiv     - ID instruction starts mult/multu (IsDiv=0) or div/divu (IsDiv=1)
//   ID_MDUse             - ID instruction needs the mult/div unit idle
//   EX_MemRead/EX_Rt     - EX instruction is a load, and its destination register
//   EX_BranchTaken       - branch in EX resolved taken
//   ExcReq               - exception/interrupt redirect this cycle
//   PCWrite, IF_ID_Write - PC and IF/ID register write enables
//   IF_ID_Flush          - active-low IF/ID flush
//   ID_EX_Bubble         - zero the ID/EX control fields
//   MDBusy               - mult/div unit busy
//   StallCycles, FlushCycles (HAZARD_PERF_CNT_EN only) - free-running event counters
module hazard_stall_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_Jump,
  input  logic        ID_MDStart,
  input  logic        ID_MDIsDiv,
  input  logic        ID_MDUse,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BranchTaken,
  input  logic        ExcReq,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCycles,
`endif
  output logic        MDBusy
);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   md_cnt_q;

  logic md_busy;
  logic lu_haz;
  logic md_haz;
  logic stall;
  logic issue;

  assign md_busy = (state_q == StMdBusy);
  assign MDBusy  = md_busy;

  // Register $0 is hardwired to zero, so a load to it never creates a dependency.
  assign lu_haz = EX_MemRead && (EX_Rt != 5'd0) &&
                  ((ID_UsesRs && (ID_Rs == EX_Rt)) || (ID_UsesRt && (ID_Rt == EX_Rt)));
  assign md_haz = ID_MDUse && md_busy;
  assign stall  = lu_haz || md_haz;
  assign issue  = ID_MDStart && !ExcReq && !EX_BranchTaken && !stall;

  // Priority-ordered control decode; outputs are held at their idle values during reset.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b1;
    ID_EX_Bubble = 1'b0;
    if (!reset) begin
      PCWrite      = 1'b1;
    end else if (ExcReq || EX_BranchTaken) begin
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (ID_Jump) begin
      // A stalled jump lands in the branch above, so the flush only fires once it advances.
      IF_ID_Flush  = 1'b0;
    end
  end

  // Mult/div latency FSM: MDBusy stays high for exactly the loaded count after issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StRun;
      md_cnt_q <= '0;
    end else if (ExcReq) begin
      // The redirect aborts any in-flight mult/div operation.
      state_q  <= StRun;
      md_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (issue) begin
            md_cnt_q <= ID_MDIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            state_q  <= StMdBusy;
          end
        end
        StMdBusy: begin
          md_cnt_q <= md_cnt_q - 1'b1;
          if (md_cnt_q == CNT_W'(1)) begin
            state_q <= StRun;
          end
        end
        default: begin
          state_q  <= StRun;
          md_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_evt;

  // Counts only cycles where the stall decision actually wins the priority order.
  assign stall_evt = stall && !ExcReq && !EX_BranchTaken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCycles <= '0;
      FlushCycles <= '0;
    end else begin
      if (stall_evt) begin
        StallCycles <= StallCycles + 32'd1;
      end
      if (!IF_ID_Flush) begin
        FlushCycles <= FlushCycles + 32'd1;
      end
    end
  end
`endif

endmodule
